// File: rtl/prt_scaler_seq.sv
// Scaler configuration sequencer: streams the VPS table on start, then runs frame-aligned.
// Latency: first VPS beat one cycle after START is sampled; RUN_OUT moves one cycle after vsync rise.
// No backpressure: the VPS stream runs one beat per cycle; STOP or loss of lock aborts it.
module prt_scaler_seq #(
  parameter int P_VPS_NUM = 10,
  parameter int P_FRM_W   = 16
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic               CTL_START_IN,
  input  logic               CTL_STOP_IN,
  input  logic               TBL_WR_IN,
  input  logic [3:0]         TBL_IDX_IN,
  input  logic [15:0]        TBL_DAT_IN,
  input  logic               VID_LOCK_IN,
  input  logic               VID_VS_IN,
  output logic [3:0]         VPS_IDX_OUT,
  output logic [15:0]        VPS_DAT_OUT,
  output logic               VPS_VLD_OUT,
  output logic               RUN_OUT,
  output logic               BUSY_OUT,
  output logic               ERR_OUT,
  output logic [P_FRM_W-1:0] FRM_CNT_OUT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'(P_VPS_NUM - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        vs_d;
  logic        vs_rise;
  logic        start_ok;
  logic [3:0]  idx_nxt;
  logic [15:0] tbl [16];

  assign vs_rise  = VID_VS_IN & ~vs_d;
  assign start_ok = CTL_START_IN & ~CTL_STOP_IN & VID_LOCK_IN;
  assign idx_nxt  = VPS_IDX_OUT + 4'd1;

  // Loss of lock overrides everything and parks the sequencer in IDLE.
  always_comb begin
    state_nxt = state;
    if (!VID_LOCK_IN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) state_nxt = ST_LOAD;
        ST_LOAD: begin
          if (CTL_STOP_IN)                    state_nxt = ST_IDLE;
          else if (VPS_IDX_OUT == LAST_IDX)   state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (CTL_STOP_IN)  state_nxt = ST_IDLE;
          else if (vs_rise) state_nxt = ST_RUN;
        end
        ST_RUN:   if (CTL_STOP_IN) state_nxt = ST_DRAIN;
        ST_DRAIN: if (vs_rise) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state       <= ST_IDLE;
      vs_d        <= 1'b0;
      VPS_IDX_OUT <= '0;
      VPS_DAT_OUT <= '0;
      VPS_VLD_OUT <= 1'b0;
      RUN_OUT     <= 1'b0;
      BUSY_OUT    <= 1'b0;
      ERR_OUT     <= 1'b0;
      FRM_CNT_OUT <= '0;
    end else begin
      state       <= state_nxt;
      vs_d        <= VID_VS_IN;
      BUSY_OUT    <= (state_nxt != ST_IDLE);
      VPS_VLD_OUT <= (state_nxt == ST_LOAD);
      RUN_OUT     <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);

      if (state == ST_IDLE && state_nxt == ST_LOAD) begin
        VPS_IDX_OUT <= 4'd0;
        VPS_DAT_OUT <= tbl[0];
        ERR_OUT     <= 1'b0;
      end else if (state == ST_LOAD && state_nxt == ST_LOAD) begin
        VPS_IDX_OUT <= idx_nxt;
        VPS_DAT_OUT <= tbl[idx_nxt];
      end

      // Writes landing mid-stream would corrupt a partially delivered set.
      if (TBL_WR_IN && state == ST_LOAD) ERR_OUT <= 1'b1;

      if (state == ST_ARM && state_nxt == ST_RUN)
        FRM_CNT_OUT <= '0;
      else if (state == ST_RUN && VID_LOCK_IN && vs_rise)
        FRM_CNT_OUT <= FRM_CNT_OUT + P_FRM_W'(1);
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else if (TBL_WR_IN && state != ST_LOAD) begin
      tbl[TBL_IDX_IN] <= TBL_DAT_IN;
    end
  end

endmodule

// File: tb/tb_prt_scaler_seq.sv
// Directed bench for prt_scaler_seq: vector table plus hand sequences for abort, wrap and reset.
module tb_prt_scaler_seq;

  localparam int FW = 4;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        wr;
    logic [3:0]  widx;
    logic [15:0] wdat;
    logic        lock;
    logic        vs;
  } in_t;

  typedef struct packed {
    logic          vld;
    logic [3:0]    idx;
    logic [15:0]   dat;
    logic          run;
    logic          busy;
    logic          err;
    logic [FW-1:0] frm;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic          CLK_IN = 1'b0;
  logic          RST_IN = 1'b0;
  logic          CTL_START_IN = 1'b0;
  logic          CTL_STOP_IN = 1'b0;
  logic          TBL_WR_IN = 1'b0;
  logic [3:0]    TBL_IDX_IN = '0;
  logic [15:0]   TBL_DAT_IN = '0;
  logic          VID_LOCK_IN = 1'b0;
  logic          VID_VS_IN = 1'b0;
  logic [3:0]    VPS_IDX_OUT;
  logic [15:0]   VPS_DAT_OUT;
  logic          VPS_VLD_OUT;
  logic          RUN_OUT;
  logic          BUSY_OUT;
  logic          ERR_OUT;
  logic [FW-1:0] FRM_CNT_OUT;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vec_q[$];

  prt_scaler_seq #(.P_VPS_NUM(10), .P_FRM_W(FW)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN),
    .CTL_START_IN(CTL_START_IN), .CTL_STOP_IN(CTL_STOP_IN),
    .TBL_WR_IN(TBL_WR_IN), .TBL_IDX_IN(TBL_IDX_IN), .TBL_DAT_IN(TBL_DAT_IN),
    .VID_LOCK_IN(VID_LOCK_IN), .VID_VS_IN(VID_VS_IN),
    .VPS_IDX_OUT(VPS_IDX_OUT), .VPS_DAT_OUT(VPS_DAT_OUT), .VPS_VLD_OUT(VPS_VLD_OUT),
    .RUN_OUT(RUN_OUT), .BUSY_OUT(BUSY_OUT), .ERR_OUT(ERR_OUT), .FRM_CNT_OUT(FRM_CNT_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  function automatic in_t mk_in(logic st, logic sp, logic wr, logic [3:0] wi,
                                logic [15:0] wd, logic lk, logic vs);
    in_t r;
    r.start = st; r.stop = sp; r.wr = wr; r.widx = wi; r.wdat = wd; r.lock = lk; r.vs = vs;
    return r;
  endfunction

  function automatic out_t mk_out(logic v, logic [3:0] ix, logic [15:0] d, logic rn,
                                  logic b, logic e, logic [FW-1:0] f);
    out_t r;
    r.vld = v; r.idx = ix; r.dat = d; r.run = rn; r.busy = b; r.err = e; r.frm = f;
    return r;
  endfunction

  function automatic out_t cur_out();
    return mk_out(VPS_VLD_OUT, VPS_IDX_OUT, VPS_DAT_OUT, RUN_OUT, BUSY_OUT, ERR_OUT, FRM_CNT_OUT);
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vec_q.push_back(v);
  endtask

  task automatic cyc(input in_t v);
    CTL_START_IN = v.start; CTL_STOP_IN = v.stop; TBL_WR_IN = v.wr;
    TBL_IDX_IN = v.widx; TBL_DAT_IN = v.wdat; VID_LOCK_IN = v.lock; VID_VS_IN = v.vs;
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic chk(input string name, input out_t exp);
    out_t got;
    got = cur_out();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got vld=%0d idx=%0d dat=%h run=%0d busy=%0d err=%0d frm=%0d want vld=%0d idx=%0d dat=%h run=%0d busy=%0d err=%0d frm=%0d",
               name, got.vld, got.idx, got.dat, got.run, got.busy, got.err, got.frm,
               exp.vld, exp.idx, exp.dat, exp.run, exp.busy, exp.err, exp.frm);
    end
  endtask

  initial begin
    in_t idle, vs1, st;
    idle = mk_in(0, 0, 0, 0, 0, 1, 0);
    vs1  = mk_in(0, 0, 0, 0, 0, 1, 1);
    st   = mk_in(1, 0, 0, 0, 0, 1, 0);

    // Table writes, then a full load with a rejected write at idx 3.
    for (int i = 0; i < 10; i++)
      add(mk_in(0, 0, 1, 4'(i), 16'h100 + 16'(i), 1, 0), mk_out(0, 0, 0, 0, 0, 0, 0));
    add(st, mk_out(1, 0, 16'h100, 0, 1, 0, 0));
    add(idle, mk_out(1, 1, 16'h101, 0, 1, 0, 0));
    add(mk_in(0, 0, 1, 3, 16'hDEAD, 1, 0), mk_out(1, 2, 16'h102, 0, 1, 1, 0));
    for (int k = 3; k < 10; k++)
      add(idle, mk_out(1, 4'(k), 16'h100 + 16'(k), 0, 1, 1, 0));
    add(idle, mk_out(0, 9, 16'h109, 0, 1, 1, 0));
    add(idle, mk_out(0, 9, 16'h109, 0, 1, 1, 0));
    add(vs1,  mk_out(0, 9, 16'h109, 1, 1, 1, 0));
    add(idle, mk_out(0, 9, 16'h109, 1, 1, 1, 0));
    for (int f = 1; f <= 5; f++) begin
      add(vs1,  mk_out(0, 9, 16'h109, 1, 1, 1, FW'(f)));
      add(idle, mk_out(0, 9, 16'h109, 1, 1, 1, FW'(f)));
    end
    // Mid-frame stop drains to the next frame boundary.
    add(mk_in(0, 1, 0, 0, 0, 1, 0), mk_out(0, 9, 16'h109, 1, 1, 1, 5));
    add(idle, mk_out(0, 9, 16'h109, 1, 1, 1, 5));
    add(vs1,  mk_out(0, 9, 16'h109, 0, 0, 1, 5));
    add(idle, mk_out(0, 9, 16'h109, 0, 0, 1, 5));
    // Restart clears ERR; stop in the 4th load cycle.
    add(st,   mk_out(1, 0, 16'h100, 0, 1, 0, 5));
    add(idle, mk_out(1, 1, 16'h101, 0, 1, 0, 5));
    add(idle, mk_out(1, 2, 16'h102, 0, 1, 0, 5));
    add(idle, mk_out(1, 3, 16'h103, 0, 1, 0, 5));
    add(mk_in(0, 1, 0, 0, 0, 1, 0), mk_out(0, 3, 16'h103, 0, 0, 0, 5));
    add(mk_in(1, 1, 0, 0, 0, 1, 0), mk_out(0, 3, 16'h103, 0, 0, 0, 5));
    add(mk_in(1, 0, 0, 0, 0, 0, 0), mk_out(0, 3, 16'h103, 0, 0, 0, 5));

    // Reset state
    RST_IN = 1'b0;
    repeat (2) @(posedge CLK_IN);
    #1;
    chk("reset_state", mk_out(0, 0, 0, 0, 0, 0, 0));
    RST_IN = 1'b1;

    foreach (vec_q[n]) begin
      cyc(vec_q[n].i);
      chk($sformatf("vec%0d", n), vec_q[n].o);
    end

    // Full load, then 17 frames to exercise the counter wrap, then lock loss.
    cyc(st);
    chk("seq_start", mk_out(1, 0, 16'h100, 0, 1, 0, 5));
    repeat (9) cyc(idle);
    chk("seq_last_beat", mk_out(1, 9, 16'h109, 0, 1, 0, 5));
    cyc(idle);
    chk("seq_arm", mk_out(0, 9, 16'h109, 0, 1, 0, 5));
    cyc(vs1);
    chk("seq_run", mk_out(0, 9, 16'h109, 1, 1, 0, 0));
    cyc(idle);
    for (int f = 0; f < 17; f++) begin
      cyc(vs1);
      cyc(idle);
    end
    chk("frm_wrap", mk_out(0, 9, 16'h109, 1, 1, 0, 1));
    cyc(mk_in(0, 0, 0, 0, 0, 0, 0));
    chk("lock_drop", mk_out(0, 9, 16'h109, 0, 0, 0, 1));
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0));
    chk("start_nolock", mk_out(0, 9, 16'h109, 0, 0, 0, 1));

    // Asynchronous reset in the middle of a load.
    cyc(st);
    repeat (3) cyc(idle);
    chk("pre_reset_load", mk_out(1, 3, 16'h103, 0, 1, 0, 1));
    #2 RST_IN = 1'b0;
    #1 chk("async_reset", mk_out(0, 0, 0, 0, 0, 0, 0));
    #1 RST_IN = 1'b1;
    @(posedge CLK_IN);
    #1;
    cyc(st);
    chk("table_cleared", mk_out(1, 0, 16'h0000, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
